flash_stream_loader: RTL and testbench

- Sequencer and arbiter for the shared byte-level SPI engine that serves boot flash and SD.
- Autonomously issues a flash READ (cmd 0x03 + 24-bit address) and streams N bytes into a memory sink, e.g. ROM/core preload from flash into SRAM at boot.
- While idle, CPU-originated SPI strobes pass straight through to the engine.
- While a stream is active, a CPU strobe is held in a one-entry pending slot with wait_n low until the stream ends.

---
 rtl/flash_stream_loader_if.sv | 28 ++
 rtl/flash_stream_loader.sv | 258 +++++++++++++++++++++++++
 tb/tb_flash_stream_loader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_stream_loader_if.sv
// flash_stream_loader_if
// Groups the two buses the loader drives:
//   mem_addr, mem_data, mem_we : loader -> memory sink. These are held until the sink accepts.
//   mem_ready                  : memory sink -> loader. The sink accepts when mem_we && mem_ready.
//   spi_send, spi_recv, spi_tx : loader -> SPI engine. These are the strobes and the transmit byte.
//   spi_rx, spi_busy           : SPI engine -> loader. These are the received byte and the busy status.
// The master modport is the loader side. The slave modport is the sink/engine side.
interface flash_stream_loader_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic        spi_send;
  logic        spi_recv;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        spi_busy;

  modport master (
    output mem_addr, mem_data, mem_we, spi_send, spi_recv, spi_tx,
    input  mem_ready, spi_rx, spi_busy
  );

  modport slave (
    input  mem_addr, mem_data, mem_we, spi_send, spi_recv, spi_tx,
    output mem_ready, spi_rx, spi_busy
  );
endinterface

// File: rtl/flash_stream_loader.sv
// flash_stream_loader
// Purpose
//   Arbitrates the shared byte-level SPI engine between the CPU and an
//   autonomous flash READ streamer. The streamer works as follows:
//   1. It sends READ_CMD and a 24-bit address.
//   2. It clocks in `length` bytes.
//   3. It writes each byte to a memory sink at offsets 0..length-1.
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, abort           : one-cycle control pulses
//   flash_addr, length     : stream parameters, sampled when the start is accepted
//   busy, done, aborted    : stream status. done and aborted are one-cycle pulses.
//   bus (master)           : memory sink write port and SPI engine port
//   cpu_send, cpu_recv     : CPU SPI strobes. These pass through when idle and are held in a slot otherwise.
//   cpu_data               : CPU transmit byte
//   cpu_flash_cs_n         : CPU-controlled flash chip-select level
//   cpu_wait_n             : low while a CPU strobe is parked in the slot
//   flash_cs_n             : flash chip select
//   sd_force_off           : high while the stream owns the bus
module flash_stream_loader #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter int         CS_SETUP = 2,
  parameter int         CS_HOLD  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [23:0]                  flash_addr,
  input  logic [15:0]                  length,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  flash_stream_loader_if.master        bus,
  input  logic                         cpu_send,
  input  logic                         cpu_recv,
  input  logic [7:0]                   cpu_data,
  input  logic                         cpu_flash_cs_n,
  output logic                         cpu_wait_n,
  output logic                         flash_cs_n,
  output logic                         sd_force_off
);

  typedef enum logic [3:0] {
    IDLE, CSLOW, CMD, A2, A1, A0, RD, STORE, CSHI, FIN
  } state_t;

  // Byte-step sub-phase. A step is complete only after the engine's busy flag
  // has been seen high and then low again.
  typedef enum logic [1:0] {PH_STROBE, PH_WAIT_HI, PH_WAIT_LO} phase_t;

  state_t      state_reg, state_next;
  phase_t      phase_reg, phase_next;
  logic [7:0]  wait_reg, wait_next;
  logic [23:0] addr_reg, addr_next;
  logic [15:0] rem_reg, rem_next;
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic [7:0]  mem_data_reg, mem_data_next;
  logic        cs_reg, cs_next;
  logic        sd_off_reg, sd_off_next;
  logic        abort_reg, abort_next;
  logic        start_pend_reg, start_pend_next;
  logic        slot_full_reg, slot_full_next;
  logic        slot_recv_reg, slot_recv_next;
  logic [7:0]  slot_data_reg, slot_data_next;

  logic        spi_send_o, spi_recv_o, mem_we_o, step_done, abort_seen;
  logic [7:0]  spi_tx_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      phase_reg      <= PH_STROBE;
      wait_reg       <= 8'd0;
      addr_reg       <= 24'd0;
      rem_reg        <= 16'd0;
      mem_addr_reg   <= 16'd0;
      mem_data_reg   <= 8'd0;
      cs_reg         <= 1'b1;
      sd_off_reg     <= 1'b0;
      abort_reg      <= 1'b0;
      start_pend_reg <= 1'b0;
      slot_full_reg  <= 1'b0;
      slot_recv_reg  <= 1'b0;
      slot_data_reg  <= 8'd0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      wait_reg       <= wait_next;
      addr_reg       <= addr_next;
      rem_reg        <= rem_next;
      mem_addr_reg   <= mem_addr_next;
      mem_data_reg   <= mem_data_next;
      cs_reg         <= cs_next;
      sd_off_reg     <= sd_off_next;
      abort_reg      <= abort_next;
      start_pend_reg <= start_pend_next;
      slot_full_reg  <= slot_full_next;
      slot_recv_reg  <= slot_recv_next;
      slot_data_reg  <= slot_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    wait_next       = wait_reg;
    addr_next       = addr_reg;
    rem_next        = rem_reg;
    mem_addr_next   = mem_addr_reg;
    mem_data_next   = mem_data_reg;
    cs_next         = cs_reg;
    sd_off_next     = sd_off_reg;
    abort_next      = abort_reg;
    start_pend_next = start_pend_reg;
    slot_full_next  = slot_full_reg;
    slot_recv_next  = slot_recv_reg;
    slot_data_next  = slot_data_reg;
    spi_send_o      = 1'b0;
    spi_recv_o      = 1'b0;
    spi_tx_o        = 8'h00;
    mem_we_o        = 1'b0;
    step_done       = 1'b0;
    abort_seen      = abort_reg | abort;

    if (state_reg != IDLE && abort) abort_next = 1'b1;

    // Outside IDLE, park the first CPU strobe. Further strobes are dropped.
    if (state_reg != IDLE && !slot_full_reg && (cpu_send || cpu_recv)) begin
      slot_full_next = 1'b1;
      slot_recv_next = cpu_recv & ~cpu_send;
      slot_data_next = cpu_data;
    end

    if (state_reg inside {CMD, A2, A1, A0, RD}) begin
      case (phase_reg)
        PH_STROBE:  begin
          spi_send_o = 1'b1;
          phase_next = PH_WAIT_HI;
        end
        PH_WAIT_HI: if (bus.spi_busy) phase_next = PH_WAIT_LO;
        default:    if (!bus.spi_busy) begin
          step_done  = 1'b1;
          phase_next = PH_STROBE;
        end
      endcase
    end

    case (state_reg)
      IDLE: begin
        abort_next = 1'b0;
        spi_send_o = cpu_send;
        spi_recv_o = cpu_recv;
        spi_tx_o   = cpu_data;
        // A parked CPU strobe goes out before any new stream can start.
        if (slot_full_reg) begin
          spi_send_o     = ~slot_recv_reg;
          spi_recv_o     = slot_recv_reg;
          spi_tx_o       = slot_data_reg;
          slot_full_next = 1'b0;
        end
        if (start || start_pend_reg) begin
          if (!slot_full_reg && !cpu_send && !cpu_recv && !bus.spi_busy) begin
            start_pend_next = 1'b0;
            addr_next       = flash_addr;
            rem_next        = length;
            mem_addr_next   = 16'd0;
            phase_next      = PH_STROBE;
            wait_next       = 8'd0;
            if (length == 16'd0) begin
              state_next = FIN;
            end else begin
              cs_next     = 1'b0;
              sd_off_next = 1'b1;
              state_next  = CSLOW;
            end
          end else begin
            start_pend_next = 1'b1;
          end
        end
      end
      CSLOW: begin
        if (wait_reg == 8'(CS_SETUP - 1)) begin
          wait_next  = 8'd0;
          state_next = CMD;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      CMD: begin
        spi_tx_o = READ_CMD;
        if (step_done) state_next = A2;
      end
      A2: begin
        spi_tx_o = addr_reg[23:16];
        if (step_done) state_next = A1;
      end
      A1: begin
        spi_tx_o = addr_reg[15:8];
        if (step_done) state_next = A0;
      end
      A0: begin
        // An abort during the header is honoured once the address is fully
        // sent, so the flash never sees a truncated READ command.
        spi_tx_o = addr_reg[7:0];
        if (step_done) begin
          wait_next  = 8'd0;
          state_next = abort_seen ? CSHI : RD;
        end
      end
      RD: begin
        spi_tx_o = 8'hFF;
        if (step_done) begin
          mem_data_next = bus.spi_rx;
          state_next    = STORE;
        end
      end
      STORE: begin
        mem_we_o = 1'b1;
        if (bus.mem_ready) begin
          mem_addr_next = mem_addr_reg + 16'd1;
          rem_next      = rem_reg - 16'd1;
          wait_next     = 8'd0;
          state_next    = (rem_reg != 16'd1 && !abort_seen) ? RD : CSHI;
        end
      end
      CSHI: begin
        if (wait_reg == 8'(CS_HOLD - 1)) begin
          wait_next   = 8'd0;
          cs_next     = 1'b1;
          sd_off_next = 1'b0;
          state_next  = FIN;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      FIN: begin
        abort_next = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state_reg != IDLE && state_reg != FIN) || start_pend_reg;
  assign done         = (state_reg == FIN);
  assign aborted      = (state_reg == FIN) && abort_reg;
  assign cpu_wait_n   = ~slot_full_reg;
  assign flash_cs_n   = (state_reg == IDLE) ? cpu_flash_cs_n : cs_reg;
  assign sd_force_off = sd_off_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_data = mem_data_reg;
  assign bus.mem_we   = mem_we_o;
  assign bus.spi_send = spi_send_o;
  assign bus.spi_recv = spi_recv_o;
  assign bus.spi_tx   = spi_tx_o;

endmodule

// File: tb/tb_flash_stream_loader.sv
module tb_flash_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [23:0] flash_addr;
  logic [15:0] length;
  logic        busy, done, aborted;
  logic        cpu_send, cpu_recv, cpu_flash_cs_n;
  logic [7:0]  cpu_data;
  logic        cpu_wait_n, flash_cs_n, sd_force_off;

  always #5 clk = ~clk;

  flash_stream_loader_if bus ();

  flash_stream_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .flash_addr     (flash_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .bus            (bus),
    .cpu_send       (cpu_send),
    .cpu_recv       (cpu_recv),
    .cpu_data       (cpu_data),
    .cpu_flash_cs_n (cpu_flash_cs_n),
    .cpu_wait_n     (cpu_wait_n),
    .flash_cs_n     (flash_cs_n),
    .sd_force_off   (sd_force_off)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash contents model
  function automatic logic [7:0] mdl(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Scoreboards: {is_flash, is_recv, byte} per strobe; {offset, byte} per write
  logic [9:0]  exp_tx_q[$];
  logic [23:0] exp_mem_q[$];

  int          eng_cnt = 0;
  logic [7:0]  eng_rx = 8'h00;
  int          fl_idx = 0;
  logic [23:0] fl_addr = 24'h0;
  int          strobe_cnt = 0;
  int          mem_cnt = 0;
  int          done_cnt = 0;
  logic        last_aborted = 1'b0;
  logic        wait_at_done = 1'b1;

  // SPI engine + flash model: 8 busy cycles per byte, rx valid when busy falls
  always @(negedge clk) begin
    if (flash_cs_n) fl_idx <= 0;
    if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        bus.spi_busy <= 1'b0;
        bus.spi_rx   <= eng_rx;
      end
      if (bus.spi_send || bus.spi_recv)
        check("spi_strobe_while_busy", {bus.spi_send, bus.spi_recv}, 0);
    end else if (bus.spi_send || bus.spi_recv) begin
      strobe_cnt   <= strobe_cnt + 1;
      bus.spi_busy <= 1'b1;
      eng_cnt      <= 8;
      if (exp_tx_q.size() == 0) begin
        check("spi_strobe_unexpected", {bus.spi_send, bus.spi_recv}, 0);
      end else begin
        check("spi_tx", bus.spi_tx, exp_tx_q[0][7:0]);
        check("spi_dir", bus.spi_recv, exp_tx_q[0][8]);
        check("spi_flash_cs_n", flash_cs_n, !exp_tx_q[0][9]);
        void'(exp_tx_q.pop_front());
      end
      if (!flash_cs_n) begin
        fl_idx <= fl_idx + 1;
        if (fl_idx >= 1 && fl_idx <= 3) fl_addr <= {fl_addr[15:0], bus.spi_tx};
        eng_rx <= (fl_idx >= 4) ? mdl(fl_addr + 24'(fl_idx - 4)) : 8'hFF;
      end else begin
        eng_rx <= 8'h00;
      end
    end
  end

  // Memory sink and completion monitor
  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_ready) begin
      mem_cnt <= mem_cnt + 1;
      if (exp_mem_q.size() == 0) begin
        check("mem_we_unexpected", bus.mem_we, 0);
      end else begin
        check("mem_addr", bus.mem_addr, exp_mem_q[0][23:8]);
        check("mem_data", bus.mem_data, exp_mem_q[0][7:0]);
        void'(exp_mem_q.pop_front());
      end
    end
    if (done) begin
      done_cnt     <= done_cnt + 1;
      last_aborted <= aborted;
      wait_at_done <= cpu_wait_n;
      check("busy_at_done", busy, 0);
      check("cs_at_done", flash_cs_n, 1);
      check("sd_off_at_done", sd_force_off, 0);
    end else if (aborted) begin
      check("aborted_without_done", aborted, 0);
    end
  end

  task automatic push_stream(input logic [23:0] a, input int n_rd, input int n_mem);
    exp_tx_q.push_back({2'b10, 8'h03});
    exp_tx_q.push_back({2'b10, a[23:16]});
    exp_tx_q.push_back({2'b10, a[15:8]});
    exp_tx_q.push_back({2'b10, a[7:0]});
    for (int i = 0; i < n_rd; i++) exp_tx_q.push_back({2'b10, 8'hFF});
    for (int i = 0; i < n_mem; i++) exp_mem_q.push_back({16'(i), mdl(a + 24'(i))});
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    flash_addr = a;
    length     = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_abort);
    int d0 = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) break;
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_aborted"}, last_aborted, exp_abort);
  endtask

  task automatic wait_mem_addr(input logic [15:0] a, input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (bus.mem_addr == a) break;
    end
    check(tag, bus.mem_addr, a);
  endtask

  task automatic wait_strobes(input int n, input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (strobe_cnt == n) break;
    end
    check(tag, strobe_cnt, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, m0, d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; flash_addr = '0; length = '0;
    cpu_send = 1'b0; cpu_recv = 1'b0; cpu_data = '0; cpu_flash_cs_n = 1'b1;
    bus.mem_ready = 1'b1; bus.spi_busy = 1'b0; bus.spi_rx = 8'h00;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_data", bus.mem_data, 0);
    check("rst_spi_send", bus.spi_send, 0);
    check("rst_spi_tx", bus.spi_tx, 0);
    check("rst_wait_n", cpu_wait_n, 1);
    check("rst_sd_off", sd_force_off, 0);
    cpu_flash_cs_n = 1'b0; #1;
    check("rst_cs_pass0", flash_cs_n, 0);
    cpu_flash_cs_n = 1'b1; #1;
    check("rst_cs_pass1", flash_cs_n, 1);
    rst_n = 1'b1;

    // 1: basic 4-byte stream
    m0 = mem_cnt;
    push_stream(24'h012345, 4, 4);
    pulse_start(24'h012345, 16'd4);
    check("t1_busy", busy, 1);
    check("t1_sd_off", sd_force_off, 1);
    check("t1_cs_low", flash_cs_n, 0);
    wait_done("t1", 1'b0);
    check("t1_mem_cnt", mem_cnt - m0, 4);
    check("t1_tx_left", exp_tx_q.size(), 0);

    // 2: zero length completes at once, no SPI traffic
    s0 = strobe_cnt;
    pulse_start(24'h00ABCD, 16'd0);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    @(posedge clk); #1;
    check("t2_done_once", done, 0);
    cpu_flash_cs_n = 1'b0; #1;
    check("t2_cs_pass", flash_cs_n, 0);
    cpu_flash_cs_n = 1'b1; #1;
    check("t2_strobes", strobe_cnt - s0, 0);

    // 3: sink stall on byte 2
    m0 = mem_cnt;
    push_stream(24'h100000, 4, 4);
    pulse_start(24'h100000, 16'd4);
    wait_mem_addr(16'd2, "t3_reach2");
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.mem_we) break;
    end
    s0 = strobe_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_stall_we", bus.mem_we, 1);
      check("t3_stall_addr", bus.mem_addr, 2);
      check("t3_stall_data", bus.mem_data, mdl(24'h100002));
    end
    check("t3_stall_strobes", strobe_cnt - s0, 0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    wait_done("t3", 1'b0);
    check("t3_mem_cnt", mem_cnt - m0, 4);

    // 4: CPU strobe parked during the stream
    push_stream(24'h000010, 2, 2);
    pulse_start(24'h000010, 16'd2);
    wait_mem_addr(16'd1, "t4_reach1");
    cpu_data = 8'hAA;
    cpu_send = 1'b1;
    exp_tx_q.push_back({2'b00, 8'hAA});
    @(posedge clk); #1;
    cpu_send = 1'b0;
    check("t4_wait_low", cpu_wait_n, 0);
    wait_done("t4", 1'b0);
    check("t4_wait_at_done", wait_at_done, 0);
    check("t4_idle_wait_n", cpu_wait_n, 0);
    check("t4_idle_send", bus.spi_send, 1);
    check("t4_idle_tx", bus.spi_tx, 8'hAA);
    @(posedge clk); #1;
    check("t4_wait_released", cpu_wait_n, 1);
    repeat (12) @(posedge clk);

    // 5: abort during A1
    m0 = mem_cnt;
    push_stream(24'hABCDEF, 0, 0);
    s0 = strobe_cnt;
    pulse_start(24'hABCDEF, 16'd100);
    wait_strobes(s0 + 3, "t5_reach_a1");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("t5", 1'b1);
    check("t5_mem_cnt", mem_cnt - m0, 0);
    check("t5_tx_left", exp_tx_q.size(), 0);

    // 6: reset during RD, then a normal stream
    d0 = done_cnt;
    push_stream(24'h002000, 2, 1);
    pulse_start(24'h002000, 16'd8);
    wait_mem_addr(16'd1, "t6_reach1");
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mem_we", bus.mem_we, 0);
    check("t6_rst_mem_addr", bus.mem_addr, 0);
    check("t6_rst_mem_data", bus.mem_data, 0);
    check("t6_rst_send", bus.spi_send, 0);
    check("t6_rst_sd_off", sd_force_off, 0);
    check("t6_rst_wait_n", cpu_wait_n, 1);
    check("t6_rst_cs", flash_cs_n, cpu_flash_cs_n);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m0 = mem_cnt;
    push_stream(24'h003000, 3, 3);
    pulse_start(24'h003000, 16'd3);
    check("t6_pending_busy", busy, 1);
    wait_done("t6", 1'b0);
    check("t6_done_total", done_cnt - d0, 1);
    check("t6_mem_cnt", mem_cnt - m0, 3);

    repeat (4) @(posedge clk); #1;
    check("end_tx_q", exp_tx_q.size(), 0);
    check("end_mem_q", exp_mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
